// File: rtl/core_pkg.sv
// Definitions shared by the core front-end: fetch FSM states and
// architectural constants that program_counter and instr_fetch must agree on.
package core_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_STALL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] CORE_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] CORE_BOOT_ADDR = 32'h1A00_0000;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding REQ/GNT/RVALID transaction, a one-entry
// instruction buffer for decode, and enable/mode control of the program counter.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = CORE_NOP_INSTR,
    parameter logic [31:0] BOOT_ADDR = CORE_BOOT_ADDR
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] PC_IN,
    output logic        PC_ENABLE,
    output logic        PC_MODE,
    output logic [31:0] PC_D,
    input  logic        JUMP_REQ,
    input  logic [31:0] JUMP_ADDR,
    output logic        INSTR_REQ,
    output logic [31:0] INSTR_ADDR,
    input  logic        INSTR_GNT,
    input  logic        INSTR_RVALID,
    input  logic [31:0] INSTR_RDATA,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    input  logic        ID_READY
);

    fetch_state_e state, state_nxt;
    logic [31:0]  addr_q;
    logic         granted;
    logic         accept;
    logic         unused_jaddr_lsb;

    // The memory shares RES, so the request is held off while reset is high.
    assign INSTR_REQ  = (state == S_REQ) && !RES;
    assign INSTR_ADDR = PC_IN;
    assign granted    = INSTR_REQ && INSTR_GNT;
    assign accept     = (state == S_WAIT) && INSTR_RVALID && !JUMP_REQ;

    assign PC_D             = {JUMP_ADDR[31:2], 2'b00};
    assign unused_jaddr_lsb = ^JUMP_ADDR[1:0];

    always_comb begin
        PC_ENABLE = 1'b0;
        PC_MODE   = 1'b0;
        if (JUMP_REQ) begin
            PC_ENABLE = 1'b1;
            PC_MODE   = 1'b1;
        end else if (granted) begin
            PC_ENABLE = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (INSTR_GNT) state_nxt = JUMP_REQ ? S_FLUSH : S_WAIT;
            end
            S_WAIT: begin
                if (JUMP_REQ)          state_nxt = INSTR_RVALID ? S_REQ : S_FLUSH;
                else if (INSTR_RVALID) state_nxt = S_STALL;
            end
            S_FLUSH: begin
                if (INSTR_RVALID) state_nxt = S_REQ;
            end
            S_STALL: begin
                if (JUMP_REQ || ID_READY) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= S_REQ;
            addr_q   <= BOOT_ADDR;
            IF_VALID <= 1'b0;
            IF_INSTR <= NOP_INSTR;
            IF_PC    <= BOOT_ADDR;
        end else begin
            state <= state_nxt;
            if (granted) addr_q <= PC_IN;
            // A redirect kills the buffer even if decode is taking it this cycle.
            if (JUMP_REQ) begin
                IF_VALID <= 1'b0;
                IF_INSTR <= NOP_INSTR;
            end else if (accept) begin
                IF_VALID <= 1'b1;
                IF_INSTR <= INSTR_RDATA;
                IF_PC    <= addr_q;
            end else if (IF_VALID && ID_READY) begin
                IF_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Cycle-vector bench for instr_fetch with a behavioural program counter
// feeding PC_IN, plus a free-running zero-wait-memory throughput run.
module tb_instr_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BOOT = 32'h1A00_0000;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] PC_IN;
    logic        PC_ENABLE, PC_MODE;
    logic [31:0] PC_D;
    logic        JUMP_REQ;
    logic [31:0] JUMP_ADDR;
    logic        INSTR_REQ;
    logic [31:0] INSTR_ADDR;
    logic        INSTR_GNT, INSTR_RVALID;
    logic [31:0] INSTR_RDATA;
    logic        IF_VALID;
    logic [31:0] IF_INSTR, IF_PC;
    logic        ID_READY;

    instr_fetch dut (
        .CLK(CLK), .RES(RES), .PC_IN(PC_IN),
        .PC_ENABLE(PC_ENABLE), .PC_MODE(PC_MODE), .PC_D(PC_D),
        .JUMP_REQ(JUMP_REQ), .JUMP_ADDR(JUMP_ADDR),
        .INSTR_REQ(INSTR_REQ), .INSTR_ADDR(INSTR_ADDR),
        .INSTR_GNT(INSTR_GNT), .INSTR_RVALID(INSTR_RVALID), .INSTR_RDATA(INSTR_RDATA),
        .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC),
        .ID_READY(ID_READY)
    );

    always #5 CLK = ~CLK;

    // Program counter model: reset to BOOT, load or +4 under fetch control.
    always @(posedge CLK) begin
        if (RES)            PC_IN <= BOOT;
        else if (PC_ENABLE) PC_IN <= PC_MODE ? PC_D : PC_IN + 32'd4;
    end

    typedef struct {
        logic        res, gnt, rvalid, jreq, rdy;
        logic [31:0] rdata, jaddr;
        logic        e_req, e_en, e_mode;
        logic [31:0] e_pcd, e_addr;
        logic        e_vld;
        logic [31:0] e_instr, e_ipc;
    } vec_t;

    typedef struct {
        logic        req, en, mode, vld;
        logic [31:0] pcd, addr, instr, ipc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    function automatic vec_t mk(input logic res, gnt, rvalid, input logic [31:0] rdata,
                                input logic jreq, input logic [31:0] jaddr, input logic rdy,
                                input logic req, en, mode, input logic [31:0] addr,
                                input logic vld, input logic [31:0] instr, ipc);
        vec_t v;
        v.res = res; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
        v.jreq = jreq; v.jaddr = jaddr; v.rdy = rdy;
        v.e_req = req; v.e_en = en; v.e_mode = mode;
        v.e_pcd = {jaddr[31:2], 2'b00}; v.e_addr = addr;
        v.e_vld = vld; v.e_instr = instr; v.e_ipc = ipc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        RES = v.res; INSTR_GNT = v.gnt; INSTR_RVALID = v.rvalid; INSTR_RDATA = v.rdata;
        JUMP_REQ = v.jreq; JUMP_ADDR = v.jaddr; ID_READY = v.rdy;
        e.req = v.e_req; e.en = v.e_en; e.mode = v.e_mode; e.pcd = v.e_pcd;
        e.addr = v.e_addr; e.vld = v.e_vld; e.instr = v.e_instr; e.ipc = v.e_ipc;
        sb.push_back(e);
    endtask

    task automatic check(input int idx);
        exp_t e;
        e = sb.pop_front();
        vec_cnt++;
        if (INSTR_REQ !== e.req || PC_ENABLE !== e.en || PC_MODE !== e.mode ||
            PC_D !== e.pcd || INSTR_ADDR !== e.addr || IF_VALID !== e.vld ||
            IF_INSTR !== e.instr || IF_PC !== e.ipc) begin
            miss_cnt++;
            $display("FAIL vec%0d: got req=%b en=%b mode=%b pcd=%h addr=%h vld=%b instr=%h pc=%h want req=%b en=%b mode=%b pcd=%h addr=%h vld=%b instr=%h pc=%h",
                     idx, INSTR_REQ, PC_ENABLE, PC_MODE, PC_D, INSTR_ADDR, IF_VALID, IF_INSTR, IF_PC,
                     e.req, e.en, e.mode, e.pcd, e.addr, e.vld, e.instr, e.ipc);
        end
    endtask

    localparam logic [31:0] J1 = 32'h1A00_0103, J2 = 32'h1A00_0200;
    localparam logic [31:0] J3 = 32'h1A00_0300, J4 = 32'h1A00_0400, J5 = 32'h1A00_0500;
    localparam logic [31:0] D1 = 32'hAAAA_0001, D2 = 32'h2222_2222;

    initial begin
        int   nvld;
        logic granted;

        //                res gnt rv rdata        jr jaddr rdy  req en md addr            vld instr ipc
        vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,   0, 0, 0, BOOT,           0, NOP, BOOT));  // reset
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,  1,   1, 1, 0, BOOT,           0, NOP, BOOT));  // first grant
        vecs.push_back(mk(0, 0, 1, 32'h93,       0, 0,  1,   0, 0, 0, BOOT+4,         0, NOP, BOOT));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  1,   0, 0, 0, BOOT+4,         1, 32'h93, BOOT));
        for (int i = 0; i < 3; i++)                                                                      // GNT low
            vecs.push_back(mk(0, 0, 0, 0,        0, 0,  1,   1, 0, 0, BOOT+4,         0, 32'h93, BOOT));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,  1,   1, 1, 0, BOOT+4,         0, 32'h93, BOOT));
        vecs.push_back(mk(0, 0, 1, D1,           0, 0,  0,   0, 0, 0, BOOT+8,         0, 32'h93, BOOT));
        for (int i = 0; i < 5; i++)                                                                      // stall
            vecs.push_back(mk(0, 0, 0, 0,        0, 0,  0,   0, 0, 0, BOOT+8,         1, D1, BOOT+4));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  1,   0, 0, 0, BOOT+8,         1, D1, BOOT+4));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  0,   1, 0, 0, BOOT+8,         0, D1, BOOT+4));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,  0,   1, 1, 0, BOOT+8,         0, D1, BOOT+4));
        vecs.push_back(mk(0, 0, 0, 0,            1, J1, 0,   0, 1, 1, BOOT+12,        0, D1, BOOT+4)); // jump in WAIT
        vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 0,  1,   0, 0, 0, 32'h1A00_0100,  0, NOP, BOOT+4));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  1,   1, 0, 0, 32'h1A00_0100,  0, NOP, BOOT+4));
        vecs.push_back(mk(0, 1, 0, 0,            1, J2, 1,   1, 1, 1, 32'h1A00_0100,  0, NOP, BOOT+4)); // jump + GNT
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  1,   0, 0, 0, J2,             0, NOP, BOOT+4));
        vecs.push_back(mk(0, 0, 0, 0,            1, J3, 1,   0, 1, 1, J2,             0, NOP, BOOT+4)); // jump in FLUSH
        vecs.push_back(mk(0, 0, 1, 32'h11111111, 0, 0,  1,   0, 0, 0, J3,             0, NOP, BOOT+4));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,  0,   1, 1, 0, J3,             0, NOP, BOOT+4));
        vecs.push_back(mk(0, 0, 1, D2,           0, 0,  0,   0, 0, 0, J3+4,           0, NOP, BOOT+4));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  0,   0, 0, 0, J3+4,           1, D2, J3));
        vecs.push_back(mk(0, 0, 0, 0,            1, J4, 0,   0, 1, 1, J3+4,           1, D2, J3));     // jump in STALL
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  0,   1, 0, 0, J4,             0, NOP, J3));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,  0,   1, 1, 0, J4,             0, NOP, J3));
        vecs.push_back(mk(1, 0, 0, 0,            0, 0,  0,   0, 0, 0, J4+4,           0, NOP, J3));    // RES in WAIT
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  0,   1, 0, 0, BOOT,           0, NOP, BOOT));
        vecs.push_back(mk(0, 0, 1, 32'h33333333, 0, 0,  1,   1, 0, 0, BOOT,           0, NOP, BOOT));  // stray RVALID
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  1,   1, 0, 0, BOOT,           0, NOP, BOOT));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,  1,   1, 1, 0, BOOT,           0, NOP, BOOT));
        vecs.push_back(mk(0, 0, 1, 32'h44444444, 1, J5, 1,   0, 1, 1, BOOT+4,         0, NOP, BOOT));  // jump + RVALID
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,  1,   1, 0, 0, J5,             0, NOP, BOOT));

        RES = 1'b1; INSTR_GNT = 1'b0; INSTR_RVALID = 1'b0; INSTR_RDATA = '0;
        JUMP_REQ = 1'b0; JUMP_ADDR = '0; ID_READY = 1'b0;
        @(posedge CLK);

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1 check(i);
        end

        // Zero-wait memory from REQ: expect one instruction every third cycle.
        nvld    = 0;
        granted = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            RES = 1'b0; INSTR_GNT = 1'b1; JUMP_REQ = 1'b0; JUMP_ADDR = '0; ID_READY = 1'b1;
            INSTR_RVALID = granted;
            INSTR_RDATA  = 32'h5000_0000 + c;
            #1;
            granted = INSTR_REQ && INSTR_GNT;
            if (IF_VALID) nvld++;
        end
        vec_cnt++;
        if (nvld != 4) begin
            miss_cnt++;
            $display("FAIL throughput: got %0d instructions in 12 cycles, want 4", nvld);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of program_counter.
- Takes the current PC and issues one instruction-memory request at a time using a REQ/GNT/RVALID handshake.
- Holds the returned word in a one-entry output buffer for the decode stage.
- Drives the program counter's enable, mode and jump-address inputs: sequential +4 advance on grant, load on jump/branch redirect.

Parameters:
- NOP_INSTR, 32'h0000_0013, IF_INSTR value during reset and after flush (addi x0,x0,0).
- BOOT_ADDR, 32'h1A00_0000, IF_PC reset value; matches program counter reset address.

Ports:
- CLK  in  1  clock, all state on rising edge
- RES  in  1  synchronous active-high reset
- PC_IN  in  32  current program counter value (program_counter PC_OUT)
- PC_ENABLE  out  1  program counter ENABLE
- PC_MODE  out  1  program counter MODE (1 = load PC_D, 0 = +4)
- PC_D  out  32  jump address to program counter, {JUMP_ADDR[31:2],2'b00}
- JUMP_REQ  in  1  single-cycle redirect request from execute
- JUMP_ADDR  in  32  redirect target
- INSTR_REQ  out  1  memory request
- INSTR_ADDR  out  32  memory address, combinationally equal to PC_IN
- INSTR_GNT  in  1  memory accepted request this cycle
- INSTR_RVALID  in  1  read data valid
- INSTR_RDATA  in  32  read data
- IF_VALID  out  1  IF_INSTR/IF_PC valid to decode
- IF_INSTR  out  32  fetched instruction
- IF_PC  out  32  address of IF_INSTR
- ID_READY  in  1  decode consumes buffer this cycle when IF_VALID=1

Behaviour:
- Reset: state=REQ, IF_VALID=0, IF_INSTR=NOP_INSTR, IF_PC=BOOT_ADDR, captured address register=BOOT_ADDR. The memory shares RES, so no response is outstanding after reset.
- States:
  - REQ: INSTR_REQ=1.
  - WAIT: one request granted, awaiting RVALID.
  - FLUSH: granted request is stale; its response is discarded.
  - STALL: buffer full, no request.
- INSTR_REQ=1 only in REQ.
- Before GNT the address may change; INSTR_ADDR follows PC_IN, which is legal on this memory interface.
- Transitions:
  - REQ: GNT&!JUMP_REQ -> WAIT; GNT&JUMP_REQ -> FLUSH; !GNT -> REQ.
  - WAIT: JUMP_REQ -> FLUSH, or -> REQ if RVALID in the same cycle, with the data discarded; RVALID&!JUMP_REQ -> STALL.
  - FLUSH: RVALID -> REQ, data dropped; else stay. JUMP_REQ does not change FLUSH.
  - STALL: JUMP_REQ or ID_READY -> REQ.
- Grant handling: on GNT in REQ, latch PC_IN into the captured address register.
- Data capture: on accepted RVALID (WAIT, no jump), IF_INSTR<=INSTR_RDATA, IF_PC<=captured address, IF_VALID<=1.
- Consume: IF_VALID&ID_READY -> IF_VALID<=0 next edge.
- Jump flush: JUMP_REQ -> IF_VALID<=0 and IF_INSTR<=NOP_INSTR next edge, regardless of ID_READY.
- PC control, combinational:
  - JUMP_REQ=1: PC_ENABLE=1, PC_MODE=1.
  - Else REQ&GNT: PC_ENABLE=1, PC_MODE=0.
  - Else PC_ENABLE=0.
  - Jump has priority over sequential advance in the same cycle.
- PC_D = {JUMP_ADDR[31:2],2'b00} always.
- Only one request is ever outstanding. A new request is issued only with the buffer empty, so RVALID never overwrites valid data.
- Latency:
  - Reset release -> INSTR_REQ the first cycle after RES deasserts.
  - GNT -> PC advanced next edge.
  - RVALID -> IF_VALID next edge.
  - Zero-wait memory (GNT with REQ, RVALID next cycle): one instruction per 3 cycles.
- RVALID in REQ or STALL is a protocol error and is ignored.
- RES mid-operation overrides all inputs and returns to reset values on the next edge.

Decomposition:
- Shared package core_pkg: state enumeration (REQ, WAIT, FLUSH, STALL), NOP_INSTR constant, BOOT_ADDR constant shared with program_counter.
- No sub-module; a single module with the FSM and the output buffer register.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0093 -> INSTR_ADDR=0x1A00_0000 one cycle after reset; PC_ENABLE=1, PC_MODE=0 on GNT; IF_VALID=1, IF_INSTR=0x0000_0093, IF_PC=0x1A00_0000; next request at 0x1A00_0004.
- GNT held low 3 cycles -> INSTR_REQ stays 1, PC_ENABLE=0 throughout, PC not advanced; advance occurs on the GNT cycle only.
- ID_READY=0 for 5 cycles after IF_VALID -> state STALL, no INSTR_REQ, IF_INSTR stable; ID_READY=1 -> IF_VALID=0 and INSTR_REQ next cycle.
- JUMP_REQ with JUMP_ADDR=0x1A00_0103 while in WAIT -> PC_D=0x1A00_0100, PC_MODE=1; following RVALID data discarded (IF_VALID stays 0); next INSTR_ADDR=0x1A00_0100.
- JUMP_REQ in the same cycle as GNT -> PC_MODE=1 (no +4); the granted response is dropped in FLUSH; JUMP_REQ in STALL -> IF_VALID cleared, IF_INSTR=NOP_INSTR.
- RES asserted in WAIT -> IF_VALID=0, IF_PC=0x1A00_0000, INSTR_REQ one cycle after release.
